nand_host_sequencer: RTL and testbench

//  Synthesizable host-side command sequencer that drives nand_master's cmd_in/activate/data_in/busy port.

---
 rtl/nand_host_pkg.sv | 58 +++++
 rtl/nand_host_script_rom.sv | 30 +++
 rtl/nand_host_sequencer.sv | 151 +++++++++++++++
 tb/tb_nand_host_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nand_host_pkg.sv
// Shared types and nand_master command codes for the host-side NAND sequencer.
// The ROM step record carries everything the sequencer FSM needs per script step.
package nand_host_pkg;

   typedef enum logic [1:0] {
      OP_INIT      = 2'd0,
      OP_READ_ID   = 2'd1,
      OP_READ_PAGE = 2'd2,
      OP_STATUS    = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_SETTLE,
      S_WAIT_BUSY,
      S_CAPTURE,
      S_EMIT
   } state_e;

   localparam logic [5:0] M_RESET               = 6'h01;
   localparam logic [5:0] M_NAND_RESET          = 6'h04;
   localparam logic [5:0] M_NAND_READ_ID        = 6'h06;
   localparam logic [5:0] M_NAND_READ           = 6'h09;
   localparam logic [5:0] MI_GET_STATUS         = 6'h0D;
   localparam logic [5:0] MI_CHIP_ENABLE        = 6'h0E;
   localparam logic [5:0] MI_RESET_INDEX        = 6'h12;
   localparam logic [5:0] MI_GET_ID_BYTE        = 6'h13;
   localparam logic [5:0] MI_GET_DATA_PAGE_BYTE = 6'h15;

   localparam int STEP_W = 2;

   typedef struct packed {
      logic [5:0] cmd;
      logic [7:0] data_in;
      logic       is_fetch;   // step returns a byte for the output stream
      logic       is_status;  // step returns the status byte
      logic       is_repeat;  // step is re-issued until the byte counter hits its end
      logic       last_step;
   } script_step_t;

   function automatic script_step_t mk_step(logic [5:0] cmd, logic [7:0] data_in, logic is_fetch,
                                            logic is_status, logic is_repeat, logic last_step);
      script_step_t s;
      s.cmd       = cmd;
      s.data_in   = data_in;
      s.is_fetch  = is_fetch;
      s.is_status = is_status;
      s.is_repeat = is_repeat;
      s.last_step = last_step;
      return s;
   endfunction

   function automatic int max2(int a, int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/nand_host_script_rom.sv
// Command script ROM: maps (operation, step) to the nand_master command for that step.
// Repeated fetch steps are a single entry; the sequencer re-issues them per byte.
module nand_host_script_rom
   import nand_host_pkg::*;
#(
   parameter logic [7:0] CE_SEL = 8'h00
) (
   input  op_e                     op,
   input  logic [STEP_W-1:0]       step,
   output script_step_t            entry
);

   always_comb begin
      entry = mk_step(6'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      case ({op, step})
         {OP_INIT, 2'd0}:      entry = mk_step(M_RESET,               8'h00,  1'b0, 1'b0, 1'b0, 1'b0);
         {OP_INIT, 2'd1}:      entry = mk_step(MI_CHIP_ENABLE,        CE_SEL, 1'b0, 1'b0, 1'b0, 1'b0);
         {OP_INIT, 2'd2}:      entry = mk_step(M_NAND_RESET,          8'h00,  1'b0, 1'b0, 1'b0, 1'b1);
         {OP_READ_ID, 2'd0}:   entry = mk_step(M_NAND_READ_ID,        8'h00,  1'b0, 1'b0, 1'b0, 1'b0);
         {OP_READ_ID, 2'd1}:   entry = mk_step(MI_GET_ID_BYTE,        8'h00,  1'b1, 1'b0, 1'b1, 1'b1);
         {OP_READ_PAGE, 2'd0}: entry = mk_step(MI_RESET_INDEX,        8'h00,  1'b0, 1'b0, 1'b0, 1'b0);
         {OP_READ_PAGE, 2'd1}: entry = mk_step(M_NAND_READ,           8'h00,  1'b0, 1'b0, 1'b0, 1'b0);
         {OP_READ_PAGE, 2'd2}: entry = mk_step(MI_RESET_INDEX,        8'h00,  1'b0, 1'b0, 1'b0, 1'b0);
         {OP_READ_PAGE, 2'd3}: entry = mk_step(MI_GET_DATA_PAGE_BYTE, 8'h00,  1'b1, 1'b0, 1'b1, 1'b1);
         {OP_STATUS, 2'd0}:    entry = mk_step(MI_GET_STATUS,         8'h00,  1'b0, 1'b1, 1'b0, 1'b1);
         default: ;
      endcase
   end

endmodule

// File: rtl/nand_host_sequencer.sv
// Host-side sequencer: runs a whole nand_master command script from one start pulse and
// returns fetched bytes on a valid/ready stream; backpressure stalls the flash-side script.
module nand_host_sequencer
   import nand_host_pkg::*;
#(
   parameter int         ID_BYTES    = 5,
   parameter int         PAGE_BYTES  = 528,
   parameter logic [7:0] CE_SEL      = 8'h00,
   parameter int         SETTLE_CYC  = 2,
   parameter int         TIMEOUT_CYC = 65535
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] op,
   output logic       idle,
   output logic       done,
   output logic       error,
   output logic [7:0] status_byte,
   output logic [5:0] nm_cmd_in,
   output logic       nm_activate,
   output logic [7:0] nm_data_in,
   input  logic [7:0] nm_data_out,
   input  logic       nm_busy,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic       byte_last
);

   localparam int BW = $clog2(max2(PAGE_BYTES, ID_BYTES) + 1);
   localparam int CW = $clog2(max2(TIMEOUT_CYC, SETTLE_CYC) + 1);
   localparam logic [BW-1:0] ID_LAST     = BW'(ID_BYTES - 1);
   localparam logic [BW-1:0] PAGE_LAST   = BW'(PAGE_BYTES - 1);
   localparam logic [CW-1:0] SETTLE_END  = CW'(SETTLE_CYC);
   localparam logic [CW-1:0] TIMEOUT_END = CW'(TIMEOUT_CYC - 1);

   state_e              state;
   op_e                 op_q;
   logic [STEP_W-1:0]   step;
   logic [CW-1:0]       cnt;
   logic [BW-1:0]       bcnt;
   script_step_t        rom;
   logic                byte_is_last;

   nand_host_script_rom #(.CE_SEL(CE_SEL)) u_rom (
      .op    (op_q),
      .step  (step),
      .entry (rom)
   );

   assign byte_is_last = (bcnt == ((op_q == OP_READ_ID) ? ID_LAST : PAGE_LAST));

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         op_q        <= OP_INIT;
         step        <= '0;
         cnt         <= '0;
         bcnt        <= '0;
         idle        <= 1'b1;
         done        <= 1'b0;
         error       <= 1'b0;
         status_byte <= 8'h00;
         nm_cmd_in   <= 6'h00;
         nm_activate <= 1'b0;
         nm_data_in  <= 8'h00;
         byte_data   <= 8'h00;
         byte_valid  <= 1'b0;
         byte_last   <= 1'b0;
      end else begin
         done        <= 1'b0;
         nm_activate <= 1'b0;
         case (state)
            S_IDLE: begin
               idle <= 1'b1;
               if (start && idle) begin
                  op_q  <= op_e'(op);
                  step  <= '0;
                  bcnt  <= '0;
                  error <= 1'b0;
                  idle  <= 1'b0;
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               nm_cmd_in   <= rom.cmd;
               nm_data_in  <= rom.data_in;
               nm_activate <= 1'b1;
               cnt         <= CW'(1);
               state       <= S_SETTLE;
            end
            // busy from nand_master lags activate; don't trust it until the settle window ends
            S_SETTLE: begin
               if (cnt >= SETTLE_END) begin
                  cnt   <= '0;
                  state <= S_WAIT_BUSY;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_WAIT_BUSY: begin
               if (!nm_busy) begin
                  if (rom.is_fetch) begin
                     state <= S_CAPTURE;
                  end else begin
                     if (rom.is_status) status_byte <= nm_data_out;
                     if (rom.last_step) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                     end else begin
                        step  <= step + STEP_W'(1);
                        state <= S_ISSUE;
                     end
                  end
               end else if (cnt >= TIMEOUT_END) begin
                  error <= 1'b1;
                  done  <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_CAPTURE: begin
               byte_data  <= nm_data_out;
               byte_last  <= byte_is_last;
               byte_valid <= 1'b1;
               state      <= S_EMIT;
            end
            S_EMIT: begin
               if (byte_ready) begin
                  byte_valid <= 1'b0;
                  byte_last  <= 1'b0;
                  bcnt       <= bcnt + BW'(1);
                  if (rom.is_repeat && !byte_is_last) begin
                     state <= S_ISSUE;
                  end else if (rom.last_step) begin
                     done  <= 1'b1;
                     state <= S_IDLE;
                  end else begin
                     step  <= step + STEP_W'(1);
                     state <= S_ISSUE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nand_host_sequencer.sv
// Directed bench for nand_host_sequencer with a small behavioural nand_master/flash responder.
module tb_nand_host_sequencer;
   import nand_host_pkg::*;

   localparam int         ID_BYTES    = 5;
   localparam int         PAGE_BYTES  = 528;
   localparam logic [7:0] CE_SEL      = 8'h00;
   localparam int         SETTLE_CYC  = 2;
   localparam int         TIMEOUT_CYC = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [1:0] op = 2'd0;
   logic       idle, done, error;
   logic [7:0] status_byte;
   logic [5:0] nm_cmd_in;
   logic       nm_activate;
   logic [7:0] nm_data_in;
   logic [7:0] nm_data_out = 8'h00;
   logic       nm_busy;
   logic [7:0] byte_data;
   logic       byte_valid;
   logic       byte_ready = 1'b1;
   logic       byte_last;

   int total = 0;
   int bad = 0;

   nand_host_sequencer #(
      .ID_BYTES(ID_BYTES), .PAGE_BYTES(PAGE_BYTES), .CE_SEL(CE_SEL),
      .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .idle(idle), .done(done), .error(error),
      .status_byte(status_byte), .nm_cmd_in(nm_cmd_in), .nm_activate(nm_activate),
      .nm_data_in(nm_data_in), .nm_data_out(nm_data_out), .nm_busy(nm_busy),
      .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_last(byte_last)
   );

   always #5 clk = ~clk;

   // flash-side responder: busy for three cycles after each activate, indexed ID/page reads
   logic [2:0] busy_cnt = 3'd0;
   bit         force_busy = 1'b0;
   int         id_idx = 0;
   int         pg_idx = 0;

   function automatic logic [7:0] id_byte(int i);
      case (i)
         0: return 8'hEC;
         1: return 8'h76;
         2: return 8'h5A;
         3: return 8'h3F;
         4: return 8'h74;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] page_byte(int i);
      return 8'((i * 37) + (i >> 8) + 5);
   endfunction

   always @(posedge clk) begin
      if (nm_activate) begin
         busy_cnt <= 3'd3;
         case (nm_cmd_in)
            M_NAND_READ_ID: id_idx <= 0;
            MI_GET_ID_BYTE: begin
               nm_data_out <= id_byte(id_idx);
               id_idx      <= id_idx + 1;
            end
            MI_RESET_INDEX: pg_idx <= 0;
            MI_GET_DATA_PAGE_BYTE: begin
               nm_data_out <= page_byte(pg_idx);
               pg_idx      <= pg_idx + 1;
            end
            MI_GET_STATUS: nm_data_out <= 8'hC0;
            default: ;
         endcase
      end else if (busy_cnt != 3'd0) begin
         busy_cnt <= busy_cnt - 3'd1;
      end
   end

   assign nm_busy = force_busy || (busy_cnt != 3'd0);

   typedef struct {
      logic [1:0] op;
      bit         slow;
      bit         stray;
      int         n_act;
      logic [5:0] cmd0;
      logic [5:0] cmd_last;
      int         n_bytes;
      logic [7:0] status;
      logic       err;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic bit at_reset();
      return (idle === 1'b1) && (done === 1'b0) && (error === 1'b0) && (status_byte === 8'h00) &&
             (nm_cmd_in === 6'h00) && (nm_activate === 1'b0) && (nm_data_in === 8'h00) &&
             (byte_valid === 1'b0) && (byte_last === 1'b0) && (byte_data === 8'h00);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (idle !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      if (idle !== 1'b1) chk("idle wait", idle, 1);
   endtask

   task automatic run_op(input vec_t v, input string tag);
      int         n_act = 0;
      logic [5:0] c0 = 6'h3F;
      logic [5:0] cl = 6'h3F;
      logic [7:0] d1 = 8'hFF;
      logic [7:0] got[$];
      bit         lasts[$];
      bit         got_done = 0;
      int         data_bad = 0;
      int         last_bad = 0;
      logic [7:0] e;
      wait_idle();
      start = 1'b1;
      op    = v.op;
      tick();
      start = 1'b0;
      chk({tag, " error cleared on start"}, error, 0);
      for (int it = 0; it < 20000; it++) begin
         byte_ready = v.slow ? ((it % 3) == 0) : 1'b1;
         if (v.stray && it == 5) begin
            start = 1'b1;
            op    = 2'd0;
         end else begin
            start = 1'b0;
         end
         if (nm_activate) begin
            if (n_act == 0) c0 = nm_cmd_in;
            if (n_act == 1) d1 = nm_data_in;
            cl = nm_cmd_in;
            n_act++;
         end
         if (byte_valid && byte_ready) begin
            got.push_back(byte_data);
            lasts.push_back(byte_last);
         end
         if (done) begin
            got_done = 1;
            chk({tag, " idle low on done"}, idle, 0);
            chk({tag, " error"}, error, v.err);
            chk({tag, " status_byte"}, status_byte, v.status);
            break;
         end
         tick();
      end
      start      = 1'b0;
      byte_ready = 1'b1;
      chk({tag, " done seen"}, got_done, 1);
      chk({tag, " activate count"}, n_act, v.n_act);
      chk({tag, " first cmd"}, c0, v.cmd0);
      chk({tag, " last cmd"}, cl, v.cmd_last);
      chk({tag, " byte count"}, got.size(), v.n_bytes);
      if (v.op == 2'd0) chk({tag, " chip enable data_in"}, d1, CE_SEL);
      foreach (got[k]) begin
         e = (v.op == 2'd1) ? id_byte(k) : page_byte(k);
         if (got[k] !== e) data_bad++;
         if (lasts[k] !== (k == got.size() - 1)) last_bad++;
      end
      chk({tag, " stream data errors"}, data_bad, 0);
      chk({tag, " byte_last placement errors"}, last_bad, 0);
      tick();
      chk({tag, " done one cycle"}, done, 0);
      chk({tag, " idle after done"}, idle, 1);
   endtask

   initial begin
      int t_act, t_done, n_act;
      vecs[0] = '{2'd0, 0, 0, 3,   M_RESET,        M_NAND_RESET,          0,   8'h00, 1'b0};
      vecs[1] = '{2'd1, 0, 0, 6,   M_NAND_READ_ID, MI_GET_ID_BYTE,        5,   8'h00, 1'b0};
      vecs[2] = '{2'd2, 1, 0, 531, MI_RESET_INDEX, MI_GET_DATA_PAGE_BYTE, 528, 8'h00, 1'b0};
      vecs[3] = '{2'd3, 0, 0, 1,   MI_GET_STATUS,  MI_GET_STATUS,         0,   8'hC0, 1'b0};
      vecs[4] = '{2'd1, 1, 1, 6,   M_NAND_READ_ID, MI_GET_ID_BYTE,        5,   8'hC0, 1'b0};
      vecs[5] = '{2'd0, 0, 0, 3,   M_RESET,        M_NAND_RESET,          0,   8'hC0, 1'b0};
      vecs[6] = '{2'd0, 0, 0, 3,   M_RESET,        M_NAND_RESET,          0,   8'h00, 1'b0};

      reset = 1'b1;
      repeat (3) tick();
      chk("reset outputs", at_reset(), 1);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 5; i++) run_op(vecs[i], $sformatf("vec%0d", i));

      // busy stuck high: timeout fires TIMEOUT_CYC+SETTLE_CYC cycles after activate
      wait_idle();
      force_busy = 1'b1;
      start = 1'b1;
      op    = 2'd3;
      tick();
      start  = 1'b0;
      t_act  = -1;
      t_done = -1;
      for (int c = 0; c < 200; c++) begin
         if (nm_activate && t_act < 0) t_act = c;
         if (done) begin
            t_done = c;
            break;
         end
         tick();
      end
      chk("timeout latency", t_done - t_act, TIMEOUT_CYC + SETTLE_CYC);
      chk("timeout error", error, 1);
      tick();
      chk("timeout error sticky", error, 1);
      force_busy = 1'b0;
      run_op(vecs[5], "init after timeout");

      // reset in the middle of a page read
      wait_idle();
      start = 1'b1;
      op    = 2'd2;
      tick();
      start = 1'b0;
      repeat (200) tick();
      reset = 1'b1;
      tick();
      chk("mid-op reset outputs", at_reset(), 1);
      reset = 1'b0;
      n_act = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (nm_activate) n_act++;
      end
      chk("no activate after reset", n_act, 0);
      run_op(vecs[6], "init after reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
